hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the pipelined core that replaces the purely combinational two-stage comparator. It keeps a per-register scoreboard of in-flight writers with separate load tracking, so RAW hazards are detected at any pipeline depth. It also supports a forwarding mode where only load-use hazards stall, and merges the SRAM wait into one stall output with a stall-cycle statistic. It sits beside the ID stage and drives the PC/IF-ID freeze and the ID/EX bubble insert.

---
 rtl/hazard_scoreboard.sv | 129 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard of in-flight writers for the ID stage.
// Tracks every in-flight writer and, separately, in-flight loads, so RAW hazards are
// caught at any pipeline depth. FWD_MODE=1 assumes ALU results are forwarded and
// stalls only on loads. The SRAM wait is merged into the same stall output.
module hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 2,
    parameter int unsigned FWD_MODE   = 0,
    parameter int unsigned STAT_W     = 16,
    parameter logic [1:0]  BNE_CODE   = 2'b10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_src1,
    input  logic [REG_ADDR_W-1:0] issue_src2,
    input  logic                  is_imm,
    input  logic [1:0]            br_type,
    input  logic                  issue_wb_en,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic                  issue_is_load,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_is_load,
    input  logic                  sram_not_ready,
    input  logic                  flush,
    output logic                  stall,
    output logic                  issue_fire,
    output logic [STAT_W-1:0]     stall_cycles
);

    localparam int unsigned    NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Entry 0 exists only to keep indexing uniform; it is held at zero.
    logic [CNT_W-1:0] cnt     [NUM_REGS];
    logic [CNT_W-1:0] ld_cnt  [NUM_REGS];
    logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
    logic [CNT_W-1:0] ld_nxt  [NUM_REGS];

    logic             src2_used;
    logic [CNT_W-1:0] eff_s1;
    logic [CNT_W-1:0] eff_s2;
    logic [CNT_W-1:0] eff_dest;
    logic [CNT_W-1:0] eff_ld_s1;
    logic [CNT_W-1:0] eff_ld_s2;
    logic             pending_s1;
    logic             pending_s2;
    logic             hazard1;
    logic             hazard2;
    logic             structural;

    // Count as seen after a same-cycle retire; a retire to an empty entry is
    // a protocol error and must not wrap the count into a false hazard.
    function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] c,
                                                    input logic             hit);
        eff_count = (hit && (c != '0)) ? c - CNT_W'(1) : c;
    endfunction

    // Effective counts for the two sources and the destination of the issuing instruction
    always_comb begin
        eff_s1    = eff_count(cnt[issue_src1], wb_valid && (wb_dest == issue_src1));
        eff_s2    = eff_count(cnt[issue_src2], wb_valid && (wb_dest == issue_src2));
        eff_dest  = eff_count(cnt[issue_dest], wb_valid && (wb_dest == issue_dest));
        eff_ld_s1 = eff_count(ld_cnt[issue_src1],
                              wb_valid && wb_is_load && (wb_dest == issue_src1));
        eff_ld_s2 = eff_count(ld_cnt[issue_src2],
                              wb_valid && wb_is_load && (wb_dest == issue_src2));
    end

    // Hazard detection and the merged stall / issue handshake
    always_comb begin
        src2_used  = !is_imm || (br_type == BNE_CODE);
        pending_s1 = (FWD_MODE != 0) ? (eff_ld_s1 != '0) : (eff_s1 != '0);
        pending_s2 = (FWD_MODE != 0) ? (eff_ld_s2 != '0) : (eff_s2 != '0);
        hazard1    = (issue_src1 != '0) && pending_s1;
        hazard2    = src2_used && (issue_src2 != '0) && pending_s2;
        structural = issue_wb_en && (issue_dest != '0) && (eff_dest == CNT_MAX);
        stall      = (issue_valid && (hazard1 || hazard2 || structural)) || sram_not_ready;
        issue_fire = issue_valid && !stall;
    end

    // Next scoreboard state: issue increments, retire decrements, flush clears all
    always_comb begin : sb_next
        logic inc;
        logic dec;
        logic inc_ld;
        logic dec_ld;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            inc    = issue_fire && issue_wb_en && (issue_dest == REG_ADDR_W'(r));
            inc_ld = inc && issue_is_load;
            dec    = wb_valid && (wb_dest == REG_ADDR_W'(r)) && (cnt[r] != '0);
            dec_ld = wb_valid && wb_is_load && (wb_dest == REG_ADDR_W'(r))
                     && (ld_cnt[r] != '0);
            if (flush || (r == 0)) begin
                cnt_nxt[r] = '0;
                ld_nxt[r]  = '0;
            end else begin
                cnt_nxt[r] = cnt[r] + CNT_W'(inc) - CNT_W'(dec);
                ld_nxt[r]  = ld_cnt[r] + CNT_W'(inc_ld) - CNT_W'(dec_ld);
            end
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r]    <= '0;
                ld_cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r]    <= cnt_nxt[r];
                ld_cnt[r] <= ld_nxt[r];
            end
        end
    end

    // Saturating count of stalled cycles; unaffected by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (default, forwarding, 4-bit statistic)
// share one stimulus; expected handshakes are queued per step and drained after settle.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [4:0] issue_src1;
    logic [4:0] issue_src2;
    logic       is_imm;
    logic [1:0] br_type;
    logic       issue_wb_en;
    logic [4:0] issue_dest;
    logic       issue_is_load;
    logic       wb_valid;
    logic [4:0] wb_dest;
    logic       wb_is_load;
    logic       sram_not_ready;
    logic       flush;

    logic        stall0, fire0, stall1, fire1, stall2, fire2;
    logic [15:0] sc0, sc1;
    logic [3:0]  sc2;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut0 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_src1(issue_src1),
        .issue_src2(issue_src2), .is_imm(is_imm), .br_type(br_type),
        .issue_wb_en(issue_wb_en), .issue_dest(issue_dest), .issue_is_load(issue_is_load),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_is_load(wb_is_load),
        .sram_not_ready(sram_not_ready), .flush(flush),
        .stall(stall0), .issue_fire(fire0), .stall_cycles(sc0));

    hazard_scoreboard #(.FWD_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_src1(issue_src1),
        .issue_src2(issue_src2), .is_imm(is_imm), .br_type(br_type),
        .issue_wb_en(issue_wb_en), .issue_dest(issue_dest), .issue_is_load(issue_is_load),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_is_load(wb_is_load),
        .sram_not_ready(sram_not_ready), .flush(flush),
        .stall(stall1), .issue_fire(fire1), .stall_cycles(sc1));

    hazard_scoreboard #(.STAT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_src1(issue_src1),
        .issue_src2(issue_src2), .is_imm(is_imm), .br_type(br_type),
        .issue_wb_en(issue_wb_en), .issue_dest(issue_dest), .issue_is_load(issue_is_load),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_is_load(wb_is_load),
        .sram_not_ready(sram_not_ready), .flush(flush),
        .stall(stall2), .issue_fire(fire2), .stall_cycles(sc2));

    typedef struct {
        string name;
        int    dut;
        logic  stall;
        logic  fire;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic out_stall(input int d);
        return (d == 0) ? stall0 : ((d == 1) ? stall1 : stall2);
    endfunction

    function automatic logic out_fire(input int d);
        return (d == 0) ? fire0 : ((d == 1) ? fire1 : fire2);
    endfunction

    task automatic expect_hs(input string name, input int dut, input logic s, input logic f);
        exp_t e;
        e.name  = name;
        e.dut   = dut;
        e.stall = s;
        e.fire  = f;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_src1 = '0; issue_src2 = '0; is_imm = 1'b0;
        br_type = 2'b00; issue_wb_en = 1'b0; issue_dest = '0; issue_is_load = 1'b0;
        wb_valid = 1'b0; wb_dest = '0; wb_is_load = 1'b0;
        sram_not_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic iss(input logic [4:0] s1, input logic [4:0] s2, input logic imm,
                       input logic [1:0] br, input logic wen, input logic [4:0] dest,
                       input logic ld);
        issue_valid = 1'b1; issue_src1 = s1; issue_src2 = s2; is_imm = imm;
        br_type = br; issue_wb_en = wen; issue_dest = dest; issue_is_load = ld;
    endtask

    task automatic ret(input logic [4:0] d, input logic ld);
        wb_valid = 1'b1; wb_dest = d; wb_is_load = ld;
    endtask

    task automatic clear_sb();
        idle();
        flush = 1'b1;
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) expect_hs("reset_idle", d, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (out_stall(e.dut) !== e.stall || out_fire(e.dut) !== e.fire) begin
                n_fail++;
                $display("FAIL %s dut%0d: stall=%b fire=%b, required stall=%b fire=%b",
                         e.name, e.dut, out_stall(e.dut), out_fire(e.dut), e.stall, e.fire);
            end
        end
        n_tests++;
        if (sc0 !== 16'd0 || sc2 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_stat: sc0=%0d sc2=%0d, required 0 0", sc0, sc2);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        clear_sb();
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0: begin
                    iss(5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd3, 1'b0);
                    expect_hs("b2b_write", 0, 1'b0, 1'b1);
                    expect_hs("b2b_write_fwd", 1, 1'b0, 1'b1);
                end
                1, 2: begin
                    iss(5'd3, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("b2b_raw_stall", 0, 1'b1, 1'b0);
                    expect_hs("b2b_alu_forward", 1, 1'b0, 1'b1);
                end
                3: begin
                    iss(5'd3, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    ret(5'd3, 1'b0);
                    expect_hs("b2b_wb_release", 0, 1'b0, 1'b1);
                end
                default: begin
                    iss(5'd0, 5'd3, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("b2b_after_wb", 0, 1'b0, 1'b1);
                end
            endcase
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (out_stall(e.dut) !== e.stall || out_fire(e.dut) !== e.fire) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: stall=%b fire=%b, required stall=%b fire=%b",
                             e.name, e.dut, out_stall(e.dut), out_fire(e.dut), e.stall, e.fire);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_forwarding();
        exp_t e;
        clear_sb();
        for (int i = 0; i < 9; i++) begin
            idle();
            case (i)
                0: begin
                    iss(5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd4, 1'b0);
                    expect_hs("fwd_alu_write", 1, 1'b0, 1'b1);
                end
                1: begin
                    iss(5'd4, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("fwd_alu_use", 1, 1'b0, 1'b1);
                    expect_hs("nofwd_alu_use", 0, 1'b1, 1'b0);
                end
                2, 7: begin
                    iss(5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd5, 1'b1);
                    if (i == 2) ret(5'd4, 1'b0);
                    expect_hs("fwd_load_write", 1, 1'b0, 1'b1);
                    expect_hs("nofwd_load_write", 0, 1'b0, 1'b1);
                end
                3, 4: begin
                    iss(5'd0, 5'd5, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("fwd_load_use", 1, 1'b1, 1'b0);
                    expect_hs("nofwd_load_use", 0, 1'b1, 1'b0);
                end
                5: begin
                    iss(5'd0, 5'd5, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    ret(5'd5, 1'b1);
                    expect_hs("fwd_load_wb", 1, 1'b0, 1'b1);
                    expect_hs("nofwd_load_wb", 0, 1'b0, 1'b1);
                end
                6: begin
                    iss(5'd5, 5'd5, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("fwd_after_load", 1, 1'b0, 1'b1);
                end
                default: begin
                    iss(5'd5, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    ret(5'd5, 1'b0);
                    expect_hs("fwd_nonload_wb_keeps_ld", 1, 1'b1, 1'b0);
                    expect_hs("nofwd_nonload_wb", 0, 1'b0, 1'b1);
                end
            endcase
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (out_stall(e.dut) !== e.stall || out_fire(e.dut) !== e.fire) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: stall=%b fire=%b, required stall=%b fire=%b",
                             e.name, e.dut, out_stall(e.dut), out_fire(e.dut), e.stall, e.fire);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_imm_bne();
        exp_t e;
        clear_sb();
        for (int i = 0; i < 8; i++) begin
            idle();
            case (i)
                0: begin
                    iss(5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd6, 1'b0);
                    expect_hs("imm_setup", 0, 1'b0, 1'b1);
                end
                1: begin
                    iss(5'd0, 5'd6, 1'b1, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("imm_src2_unused", 0, 1'b0, 1'b1);
                end
                2: begin
                    iss(5'd0, 5'd6, 1'b1, 2'b10, 1'b0, 5'd0, 1'b0);
                    expect_hs("bne_src2_used", 0, 1'b1, 1'b0);
                end
                3: begin
                    iss(5'd0, 5'd6, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("reg_src2_used", 0, 1'b1, 1'b0);
                end
                4: begin
                    iss(5'd0, 5'd6, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0);
                    expect_hs("imm_other_br", 0, 1'b0, 1'b1);
                end
                5, 6: begin
                    iss(5'd0, 5'd0, 1'b0, 2'b10, 1'b1, 5'd0, 1'b0);
                    expect_hs("r0_write_read", 0, 1'b0, 1'b1);
                    expect_hs("r0_write_read_fwd", 1, 1'b0, 1'b1);
                end
                default: begin
                    iss(5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    ret(5'd0, 1'b0);
                    expect_hs("r0_wb", 0, 1'b0, 1'b1);
                end
            endcase
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (out_stall(e.dut) !== e.stall || out_fire(e.dut) !== e.fire) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: stall=%b fire=%b, required stall=%b fire=%b",
                             e.name, e.dut, out_stall(e.dut), out_fire(e.dut), e.stall, e.fire);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        clear_sb();
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i != 6) iss(5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd7, 1'b0);
            case (i)
                0, 1, 2, 7: begin
                    expect_hs("sat_fill", 0, 1'b0, 1'b1);
                    expect_hs("sat_fill_s4", 2, 1'b0, 1'b1);
                end
                3, 5: begin
                    expect_hs("sat_full", 0, 1'b1, 1'b0);
                    expect_hs("sat_full_fwd", 1, 1'b1, 1'b0);
                end
                4: begin
                    ret(5'd7, 1'b0);
                    expect_hs("sat_full_with_wb", 0, 1'b0, 1'b1);
                end
                default: begin
                    ret(5'd7, 1'b0);
                    expect_hs("sat_wb_only", 0, 1'b0, 1'b0);
                end
            endcase
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (out_stall(e.dut) !== e.stall || out_fire(e.dut) !== e.fire) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: stall=%b fire=%b, required stall=%b fire=%b",
                             e.name, e.dut, out_stall(e.dut), out_fire(e.dut), e.stall, e.fire);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        clear_sb();
        for (int i = 0; i < 6; i++) begin
            idle();
            case (i)
                0: begin
                    iss(5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd8, 1'b0);
                    expect_hs("flush_wr_r8", 0, 1'b0, 1'b1);
                end
                1: begin
                    iss(5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd9, 1'b0);
                    expect_hs("flush_wr_r9", 0, 1'b0, 1'b1);
                end
                2: begin
                    iss(5'd8, 5'd9, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("flush_pre_stall", 0, 1'b1, 1'b0);
                end
                3: begin
                    flush = 1'b1;
                    iss(5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd10, 1'b1);
                    expect_hs("flush_cycle_issue", 0, 1'b0, 1'b1);
                    expect_hs("flush_cycle_issue_fwd", 1, 1'b0, 1'b1);
                end
                4: begin
                    iss(5'd8, 5'd9, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("flush_cleared", 0, 1'b0, 1'b1);
                end
                default: begin
                    iss(5'd10, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("flush_overrides_issue", 0, 1'b0, 1'b1);
                    expect_hs("flush_overrides_load", 1, 1'b0, 1'b1);
                end
            endcase
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (out_stall(e.dut) !== e.stall || out_fire(e.dut) !== e.fire) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: stall=%b fire=%b, required stall=%b fire=%b",
                             e.name, e.dut, out_stall(e.dut), out_fire(e.dut), e.stall, e.fire);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        clear_sb();
        for (int i = 0; i < 4; i++) begin
            idle();
            case (i)
                0: begin
                    iss(5'd0, 5'd0, 1'b0, 2'b00, 1'b1, 5'd11, 1'b0);
                    expect_hs("rstmid_write", 0, 1'b0, 1'b1);
                end
                1: begin
                    iss(5'd11, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    sram_not_ready = 1'b1;
                    expect_hs("rstmid_stalled", 0, 1'b1, 1'b0);
                end
                2: begin
                    iss(5'd11, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    sram_not_ready = 1'b1;
                    #2 rst = 1'b1;
                    expect_hs("rstmid_sram_only", 0, 1'b1, 1'b0);
                end
                default: begin
                    iss(5'd11, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
                    expect_hs("rstmid_cleared", 0, 1'b0, 1'b1);
                end
            endcase
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (out_stall(e.dut) !== e.stall || out_fire(e.dut) !== e.fire) begin
                    n_fail++;
                    $display("FAIL %s dut%0d: stall=%b fire=%b, required stall=%b fire=%b",
                             e.name, e.dut, out_stall(e.dut), out_fire(e.dut), e.stall, e.fire);
                end
            end
            if (i == 2) begin
                n_tests++;
                if (sc0 !== 16'd0) begin
                    n_fail++;
                    $display("FAIL rstmid_stat: stall_cycles=%0d, required 0", sc0);
                end
            end
            @(negedge clk);
        end
        idle();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stats();
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int phase = 0; phase < 3; phase++) begin
            for (int c = 0; c < ((phase == 2) ? 5 : 10); c++) begin
                idle();
                sram_not_ready = 1'b1;
                if (c == 0) begin
                    #1;
                    n_tests++;
                    if (stall0 !== 1'b1 || fire0 !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stat_sram_stall: stall=%b fire=%b, required 1 0",
                                 stall0, fire0);
                    end
                end
                @(negedge clk);
            end
            idle();
            #1;
            n_tests++;
            case (phase)
                0: if (sc0 !== 16'd10 || sc2 !== 4'd10) begin
                    n_fail++;
                    $display("FAIL stat_10: sc0=%0d sc2=%0d, required 10 10", sc0, sc2);
                end
                1: if (sc0 !== 16'd20 || sc2 !== 4'd15) begin
                    n_fail++;
                    $display("FAIL stat_20: sc0=%0d sc2=%0d, required 20 15", sc0, sc2);
                end
                default: if (sc1 !== 16'd25 || sc2 !== 4'd15) begin
                    n_fail++;
                    $display("FAIL stat_25: sc1=%0d sc2=%0d, required 25 15", sc1, sc2);
                end
            endcase
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_forwarding();
        test_imm_bne();
        test_saturation();
        test_flush();
        test_reset_mid();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
